// File: rtl/stream_blur3x3_if.sv
// Handshake bundle for stream_blur3x3: pixel input stream, pixel output stream,
// the bypass control input and the frame-error flag.
interface stream_blur3x3_if #(
    parameter int PIX_W = 12
);
    logic             blur_en;
    logic             s_valid;
    logic             s_ready;
    logic             s_sof;
    logic [PIX_W-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic             m_sof;
    logic             m_eof;
    logic [PIX_W-1:0] m_data;
    logic             frame_err;

    modport slave (
        input  blur_en, s_valid, s_sof, s_data, m_ready,
        output s_ready, m_valid, m_sof, m_eof, m_data, frame_err
    );

    modport master (
        output blur_en, s_valid, s_sof, s_data, m_ready,
        input  s_ready, m_valid, m_sof, m_eof, m_data, frame_err
    );
endinterface

// File: rtl/stream_blur3x3.sv
// Streaming 3x3 smoothing filter (1/16 * [1 1 1; 1 8 1; 1 1 1]) with border pass-through and bypass.
// Define BLUR_ROUND_EN for round-half-up interior results instead of truncation.
module stream_blur3x3 #(
    parameter int CHANNELS   = 3,
    parameter int CH_WIDTH   = 4,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input  logic clk,
    input  logic rst_n,
    stream_blur3x3_if.slave bus
);
    localparam int PIX_W = CHANNELS * CH_WIDTH;
    localparam int SW    = CH_WIDTH + 4;
    localparam int N     = IMG_WIDTH * IMG_HEIGHT;
    localparam int NW    = $clog2(N + IMG_WIDTH + 1);
    localparam int CW    = $clog2(IMG_WIDTH);
    localparam int RW    = $clog2(IMG_HEIGHT);

    localparam logic [NW-1:0] N_LAST    = NW'(N - 1);
    localparam logic [NW-1:0] F_LAST    = NW'(N + IMG_WIDTH);
    localparam logic [NW-1:0] OUT_START = NW'(IMG_WIDTH + 1);
    localparam logic [CW-1:0] C_LAST    = CW'(IMG_WIDTH - 1);
    localparam logic [RW-1:0] R_LAST    = RW'(IMG_HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t           state_q, state_d;
    logic             alive_q;
    logic [NW-1:0]    n_q;
    logic [CW-1:0]    in_col_q;
    logic [CW-1:0]    out_col_q;
    logic [RW-1:0]    out_row_q;
    logic             blur_q;
    logic             m_valid_q, m_sof_q, m_eof_q, err_q;
    logic [PIX_W-1:0] m_data_q;
    // Columns n-2 and n-1 of the window; column n comes straight from the line buffers.
    logic [PIX_W-1:0] win_q [3][2];

    logic [PIX_W-1:0] lb0_mem [IMG_WIDTH];
    logic [PIX_W-1:0] lb1_mem [IMG_WIDTH];

    logic             out_free, beat, frame_start, restart, load, s_ready_w, border;
    logic [CW-1:0]    lb_addr;
    logic [PIX_W-1:0] col_new [3];
    logic [PIX_W-1:0] filt;
    logic [PIX_W-1:0] out_pix;

    assign out_free = !m_valid_q || bus.m_ready;

    always_comb begin
        state_d     = state_q;
        s_ready_w   = 1'b0;
        beat        = 1'b0;
        frame_start = 1'b0;
        case (state_q)
            IDLE: begin
                s_ready_w = alive_q;
                if (alive_q && bus.s_valid && bus.s_sof) begin
                    beat        = 1'b1;
                    frame_start = 1'b1;
                    state_d     = RUN;
                end
            end
            RUN: begin
                s_ready_w = out_free;
                if (bus.s_valid && out_free) begin
                    beat        = 1'b1;
                    frame_start = bus.s_sof;
                    if (!bus.s_sof && n_q == N_LAST) state_d = FLUSH;
                end
            end
            FLUSH: begin
                beat = out_free;
                if (out_free && n_q == F_LAST) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign restart = frame_start && (state_q == RUN);
    assign load    = beat && !frame_start && (n_q >= OUT_START);
    assign lb_addr = frame_start ? '0 : in_col_q;

    assign col_new[0] = lb1_mem[lb_addr];
    assign col_new[1] = lb0_mem[lb_addr];
    assign col_new[2] = bus.s_data;

    function automatic logic [SW-1:0] chan(input logic [PIX_W-1:0] p, input int k);
        return SW'(p[k*CH_WIDTH +: CH_WIDTH]);
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
            logic [SW-1:0] sum;
            assign sum = chan(win_q[0][0], gi) + chan(win_q[0][1], gi) + chan(col_new[0], gi)
                       + chan(win_q[1][0], gi) + (chan(win_q[1][1], gi) << 3) + chan(col_new[1], gi)
                       + chan(win_q[2][0], gi) + chan(win_q[2][1], gi) + chan(col_new[2], gi);
`ifdef BLUR_ROUND_EN
            assign filt[gi*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'((sum + SW'(8)) >> 4);
`else
            assign filt[gi*CH_WIDTH +: CH_WIDTH] = CH_WIDTH'(sum >> 4);
`endif
        end
    endgenerate

    assign border  = (out_row_q == '0) || (out_row_q == R_LAST) ||
                     (out_col_q == '0) || (out_col_q == C_LAST);
    assign out_pix = (border || !blur_q) ? win_q[1][1] : filt;

    always_ff @(posedge clk) begin
        if (beat) begin
            lb0_mem[lb_addr] <= bus.s_data;
            lb1_mem[lb_addr] <= lb0_mem[lb_addr];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            alive_q   <= 1'b0;
            n_q       <= '0;
            in_col_q  <= '0;
            out_col_q <= '0;
            out_row_q <= '0;
            blur_q    <= 1'b1;
            m_valid_q <= 1'b0;
            m_sof_q   <= 1'b0;
            m_eof_q   <= 1'b0;
            m_data_q  <= '0;
            err_q     <= 1'b0;
            win_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            alive_q <= 1'b1;
            err_q   <= restart;
            if (beat) begin
                for (int r = 0; r < 3; r++) begin
                    win_q[r][0] <= win_q[r][1];
                    win_q[r][1] <= col_new[r];
                end
                if (frame_start) begin
                    n_q       <= NW'(1);
                    in_col_q  <= CW'(1);
                    out_col_q <= '0;
                    out_row_q <= '0;
                    blur_q    <= bus.blur_en;
                end else begin
                    n_q      <= n_q + NW'(1);
                    in_col_q <= (in_col_q == C_LAST) ? '0 : in_col_q + CW'(1);
                end
            end
            if (load) begin
                m_valid_q <= 1'b1;
                m_data_q  <= out_pix;
                m_sof_q   <= (out_row_q == '0) && (out_col_q == '0);
                m_eof_q   <= (out_row_q == R_LAST) && (out_col_q == C_LAST);
                if (out_col_q == C_LAST) begin
                    out_col_q <= '0;
                    out_row_q <= out_row_q + RW'(1);
                end else begin
                    out_col_q <= out_col_q + CW'(1);
                end
            end else if (restart || bus.m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign bus.s_ready   = s_ready_w;
    assign bus.m_valid   = m_valid_q;
    assign bus.m_sof     = m_sof_q;
    assign bus.m_eof     = m_eof_q;
    assign bus.m_data    = m_data_q;
    assign bus.frame_err = err_q;
endmodule

// File: tb/tb_stream_blur3x3.sv
// Scoreboard bench for stream_blur3x3 on a 4x3 frame: expected pixels are queued from a
// reference model as frames are driven and compared as the filter emits them.
module tb_stream_blur3x3;
    localparam int W = 4;
    localparam int H = 3;
    localparam int N = W * H;

    typedef struct packed {
        logic [11:0] data;
        logic        sof;
        logic        eof;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    stream_blur3x3_if #(.PIX_W(12)) bus ();

    stream_blur3x3 #(.CHANNELS(3), .CH_WIDTH(4), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    exp_t        exp_q[$];
    logic [11:0] frm [N];
    int          n_checks = 0;
    int          n_pass   = 0;
    int          err_cnt  = 0;
    int          tcount   = 0;
    int          in_idx   = 0;
    int          acc5_t   = 0;
    bit          lat_arm  = 0;
    bit          rand_rdy = 0;
    logic        prev_err = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [11:0] model_px(input int r, input int c, input logic blur);
        logic [11:0] res;
        int sum;
        if (!blur || r == 0 || r == H-1 || c == 0 || c == W-1) return frm[r*W + c];
        res = '0;
        for (int k = 0; k < 3; k++) begin
            sum = 0;
            for (int dr = -1; dr <= 1; dr++)
                for (int dc = -1; dc <= 1; dc++) begin
                    logic [11:0] p;
                    p = frm[(r+dr)*W + c + dc];
                    sum += (dr == 0 && dc == 0) ? 8 * int'(p[4*k +: 4]) : int'(p[4*k +: 4]);
                end
`ifdef BLUR_ROUND_EN
            sum += 8;
`endif
            res[4*k +: 4] = 4'(sum >> 4);
        end
        return res;
    endfunction

    task automatic push_frame(input int count, input logic blur);
        for (int m = 0; m < count; m++)
            exp_q.push_back('{data: model_px(m / W, m % W, blur), sof: (m == 0), eof: (m == N-1)});
    endtask

    task automatic send(input logic [11:0] d, input logic sof);
        int waitc = 0;
        bus.s_valid = 1'b1;
        bus.s_sof   = sof;
        bus.s_data  = d;
        @(negedge clk);
        while (!bus.s_ready && waitc < 1000) begin
            @(negedge clk);
            waitc++;
        end
        check("s_ready_timeout", {31'd0, bus.s_ready}, 32'd1);
        @(posedge clk);
        #1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
    endtask

    task automatic send_frame(input logic blur);
        bus.blur_en = blur;
        for (int n = 0; n < N; n++) send(frm[n], n == 0);
    endtask

    task automatic drain();
        int i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(negedge clk);
            i++;
        end
        check("drain_empty", exp_q.size(), 0);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            bus.m_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: one printed line per accepted output pixel.
    always @(negedge clk) begin
        tcount++;
        if (rst_n) begin
            if (bus.s_valid && bus.s_ready) begin
                if (bus.s_sof) in_idx = 0;
                else in_idx++;
                if (in_idx == 5) acc5_t = tcount;
            end
            if (bus.m_valid) begin
                if (lat_arm) begin
                    check("first_valid_latency", tcount - acc5_t, 1);
                    lat_arm = 0;
                end
                if (exp_q.size() == 0) begin
                    check("spurious_output", 1, 0);
                end else begin
                    check("m_data", bus.m_data, exp_q[0].data);
                    check("m_sof", bus.m_sof, exp_q[0].sof);
                    check("m_eof", bus.m_eof, exp_q[0].eof);
                    if (bus.m_ready) begin
                        $display("out data=%03h sof=%b eof=%b", bus.m_data, bus.m_sof, bus.m_eof);
                        void'(exp_q.pop_front());
                    end
                end
            end
            if (bus.frame_err) begin
                err_cnt++;
                check("frame_err_width", prev_err, 0);
            end
            prev_err = bus.frame_err;
        end
    end

    initial begin
        int err_before;
        bus.blur_en = 1'b1;
        bus.s_valid = 1'b0;
        bus.s_sof   = 1'b0;
        bus.s_data  = '0;
        bus.m_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_m_valid", bus.m_valid, 0);
        check("rst_m_sof", bus.m_sof, 0);
        check("rst_m_eof", bus.m_eof, 0);
        check("rst_m_data", bus.m_data, 0);
        check("rst_frame_err", bus.frame_err, 0);
        check("rst_s_ready", bus.s_ready, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Saturated frame: every output stays 0xFFF; also checks first-output latency.
        for (int i = 0; i < N; i++) frm[i] = 12'hFFF;
        push_frame(N, 1'b1);
        lat_arm = 1;
        send_frame(1'b1);
        drain();

        // Single bright centre pixel.
        for (int i = 0; i < N; i++) frm[i] = 12'h000;
        frm[W + 1] = 12'h888;
        push_frame(N, 1'b1);
        send_frame(1'b1);
        drain();

        // Ramp in bypass mode.
        for (int i = 0; i < N; i++) frm[i] = 12'(i);
        push_frame(N, 1'b0);
        send_frame(1'b0);
        drain();

        // Random frames with random downstream back-pressure.
        rand_rdy = 1;
        for (int f = 0; f < 4; f++) begin
            logic blur;
            blur = 1'($urandom_range(0, 1));
            for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
            push_frame(N, blur);
            send_frame(blur);
        end
        drain();
        rand_rdy = 0;
        @(posedge clk);
        #1;

        // Premature s_sof at index 7: outputs 0 and 1 of the aborted frame still leave.
        err_before = err_cnt;
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        exp_q.push_back('{data: frm[0], sof: 1'b1, eof: 1'b0});
        exp_q.push_back('{data: frm[1], sof: 1'b0, eof: 1'b0});
        bus.blur_en = 1'b1;
        for (int n = 0; n < 7; n++) send(frm[n], n == 0);
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        push_frame(N, 1'b1);
        send_frame(1'b1);
        drain();
        check("frame_err_count", err_cnt - err_before, 1);

        // Reset during FLUSH: outputs 0..5 leave before the reset lands.
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        push_frame(6, 1'b1);
        send_frame(1'b1);
        rst_n = 1'b0;
        #1;
        check("flushrst_m_valid", bus.m_valid, 0);
        check("flushrst_m_data", bus.m_data, 0);
        check("flushrst_m_sof", bus.m_sof, 0);
        check("flushrst_m_eof", bus.m_eof, 0);
        check("flushrst_s_ready", bus.s_ready, 0);
        check("flushrst_frame_err", bus.frame_err, 0);
        check("flushrst_queue", exp_q.size(), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++) frm[i] = 12'($urandom);
        push_frame(N, 1'b1);
        send_frame(1'b1);
        drain();

        check("frame_err_total", err_cnt, 1);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
